// File: rtl/wave_dac_driver.sv
// rtl/wave_dac_driver.sv - samples NCO address at a fixed rate, reads wave RAM, shifts 16b frames to an SPI DAC
// Optional midscale mute input enabled by defining WAVE_DAC_MUTE_EN.
module wave_dac_driver #(
  parameter int                   ADDR_WIDTH   = 13,
  parameter int                   SAMPLE_WIDTH = 12,
  parameter int                   CMD_BITS     = 4,
  parameter logic [CMD_BITS-1:0]  DAC_CMD      = 4'b0011,
  parameter int                   DIV_WIDTH    = 8,
  parameter int                   SCLK_HALF    = 2
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
`ifdef WAVE_DAC_MUTE_EN
  input  logic                    i_mute,
`endif
  input  logic [ADDR_WIDTH-1:0]   i_address,
  input  logic [DIV_WIDTH-1:0]    i_rate_div,
  output logic [ADDR_WIDTH-1:0]   o_ram_address,
  output logic                    o_ram_read_en,
  input  logic [SAMPLE_WIDTH-1:0] i_ram_data,
  output logic                    o_dac_cs_n,
  output logic                    o_dac_sclk,
  output logic                    o_dac_mosi,
  output logic                    o_busy,
  output logic                    o_frame_done,
  output logic                    o_overrun
);

  localparam int FRAME_BITS = CMD_BITS + SAMPLE_WIDTH;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int HALF_W     = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(SCLK_HALF - 1);
  localparam logic [SAMPLE_WIDTH-1:0] MIDSCALE = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_SHIFT   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [ADDR_WIDTH-1:0]   addr_q1;
  logic [ADDR_WIDTH-1:0]   addr_q2;
  logic [ADDR_WIDTH-1:0]   addr_hold;
  logic [DIV_WIDTH-1:0]    rate_cnt;
  logic                    tick;
  logic [2:0]              state;
  logic [1:0]              retry_cnt;
  logic                    addr_accept;
  logic [FRAME_BITS-1:0]   shift_reg;
  logic [HALF_W-1:0]       half_cnt;
  logic [HALF_W-1:0]       half_now;
  logic                    phase_end;
  logic [BIT_W-1:0]        bit_cnt;
  logic [SAMPLE_WIDTH-1:0] sample;

  always_ff @(posedge i_clock) begin
    addr_q1 <= i_address;
    addr_q2 <= addr_q1;
  end

  assign tick = (rate_cnt == '0);

  always_ff @(posedge i_clock) begin
    if (i_reset || tick) begin
      rate_cnt <= i_rate_div;
    end else begin
      rate_cnt <= rate_cnt - DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_overrun <= 1'b0;
    end else if (tick && (state != S_IDLE)) begin
      o_overrun <= 1'b1;
    end
  end

  // Two equal synchroniser stages mean the address was stable across a clock;
  // after three mismatches the latest value is taken anyway.
  assign addr_accept   = (state == S_READ) && ((addr_q1 == addr_q2) || (retry_cnt == 2'd3));
  assign o_ram_read_en = addr_accept;
  assign o_ram_address = (state == S_READ) ? addr_q2 : addr_hold;
  assign o_busy        = (state != S_IDLE);
  assign o_frame_done  = (state == S_DONE);

`ifdef WAVE_DAC_MUTE_EN
  assign sample = i_mute ? MIDSCALE : i_ram_data;
`else
  assign sample = i_ram_data;
`endif

  // The CAPTURE clock is the first clock of bit 15's low phase.
  assign half_now  = (state == S_CAPTURE) ? '0 : half_cnt;
  assign phase_end = (half_now == HALF_LAST);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= S_IDLE;
      retry_cnt  <= 2'd0;
      addr_hold  <= '0;
      shift_reg  <= '0;
      half_cnt   <= '0;
      bit_cnt    <= '0;
      o_dac_cs_n <= 1'b1;
      o_dac_sclk <= 1'b0;
      o_dac_mosi <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (tick) begin
            state     <= S_READ;
            retry_cnt <= 2'd0;
          end
        end

        S_READ: begin
          if (addr_accept) begin
            addr_hold  <= addr_q2;
            state      <= S_CAPTURE;
            o_dac_cs_n <= 1'b0;
            o_dac_sclk <= 1'b0;
            // Bit 15 is always the command MSB, so it can go out before the RAM data arrives.
            o_dac_mosi <= DAC_CMD[CMD_BITS-1];
          end else begin
            retry_cnt <= retry_cnt + 2'd1;
          end
        end

        S_CAPTURE: begin
          shift_reg <= {DAC_CMD, sample};
          bit_cnt   <= '0;
          state     <= S_SHIFT;
          if (phase_end) begin
            half_cnt   <= '0;
            o_dac_sclk <= 1'b1;
          end else begin
            half_cnt <= half_now + HALF_W'(1);
          end
        end

        S_SHIFT: begin
          if (!phase_end) begin
            half_cnt <= half_cnt + HALF_W'(1);
          end else begin
            half_cnt <= '0;
            if (!o_dac_sclk) begin
              o_dac_sclk <= 1'b1;
            end else if (bit_cnt == BIT_LAST) begin
              o_dac_sclk <= 1'b0;
              o_dac_mosi <= 1'b0;
              o_dac_cs_n <= 1'b1;
              state      <= S_DONE;
            end else begin
              o_dac_sclk <= 1'b0;
              o_dac_mosi <= shift_reg[FRAME_BITS-2];
              shift_reg  <= shift_reg << 1;
              bit_cnt    <= bit_cnt + BIT_W'(1);
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
